// File: rtl/lane_mask_dispatcher.sv
// lane_mask_dispatcher
// Routes tagged mask beats from the lane mask unit to the functional unit
// that currently owns the beat's vector instruction ID. Each FU has a small
// circular queue, so several masked instructions can be in flight in
// different units at once.
module lane_mask_dispatcher #(
    parameter int unsigned NrFUs          = 2,
    parameter int unsigned NrVInsn        = 8,
    parameter int unsigned MaskQueueDepth = 2,
    parameter int unsigned StrbWidth      = 8,
    localparam int unsigned IdW           = (NrVInsn > 1) ? $clog2(NrVInsn) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NrFUs-1:0]                    claim_valid_i,
    input  logic [NrFUs-1:0][IdW-1:0]           claim_id_i,
    input  logic [NrFUs-1:0][NrVInsn-1:0]       vinsn_done_i,
    input  logic [StrbWidth-1:0]                mask_i,
    input  logic [IdW-1:0]                      mask_id_i,
    input  logic                                mask_valid_i,
    output logic                                mask_ready_o,
    output logic [NrFUs-1:0][StrbWidth-1:0]     fu_mask_o,
    output logic [NrFUs-1:0][IdW-1:0]           fu_mask_id_o,
    output logic [NrFUs-1:0]                    fu_mask_valid_o,
    input  logic [NrFUs-1:0]                    fu_mask_ready_i,
    output logic                                claim_conflict_o
);

    localparam int unsigned FuW  = (NrFUs > 1) ? $clog2(NrFUs) : 1;
    localparam int unsigned PtrW = (MaskQueueDepth > 1) ? $clog2(MaskQueueDepth) : 1;
    localparam int unsigned CntW = $clog2(MaskQueueDepth + 1);
    // Wide enough to hold (pointer + advance) before the modulo wrap.
    localparam int unsigned SumW = CntW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(MaskQueueDepth);

    // Ownership table
    logic [NrVInsn-1:0]     r_owned;
    logic [FuW-1:0]         r_owner [NrVInsn];
    logic                   r_conflict;

    // Per-FU queues
    logic [StrbWidth-1:0]   r_data [NrFUs][MaskQueueDepth];
    logic [IdW-1:0]         r_tag  [NrFUs][MaskQueueDepth];
    logic [PtrW-1:0]        r_rptr [NrFUs];
    logic [PtrW-1:0]        r_wptr [NrFUs];
    logic [CntW-1:0]        r_cnt  [NrFUs];

    // Claim/release decode
    logic [NrVInsn-1:0]     w_claimed;
    logic [NrVInsn-1:0]     w_multi;
    logic [NrVInsn-1:0]     w_release;
    logic [FuW-1:0]         w_claimer [NrVInsn];
    logic                   w_conflict;

    // Routing
    logic [FuW-1:0]         w_tgt;
    logic                   w_id_owned;
    logic [CntW-1:0]        w_tgt_cnt;
    logic                   w_ready;

    // Queue next-state
    logic [NrFUs-1:0]       w_push;
    logic [NrFUs-1:0]       w_pop;
    logic [CntW-1:0]        w_flush_cnt [NrFUs];
    logic [CntW-1:0]        w_remove    [NrFUs];
    logic [CntW-1:0]        w_cnt_nxt   [NrFUs];
    logic [PtrW-1:0]        w_rptr_nxt  [NrFUs];
    logic [PtrW-1:0]        w_wptr_nxt  [NrFUs];

    // Pointer advance modulo the queue depth (depth need not be a power of two).
    function automatic logic [PtrW-1:0] wrap_add(input logic [PtrW-1:0] base,
                                                 input logic [CntW-1:0] inc);
        logic [SumW-1:0] s;
        s = SumW'(base) + SumW'(inc);
        if (s >= SumW'(MaskQueueDepth)) begin
            s = s - SumW'(MaskQueueDepth);
        end
        return s[PtrW-1:0];
    endfunction

    // Decode claims per ID: lowest-index claimer wins, flag double claims and
    // claims on IDs still held. An ID released by its owner in the same cycle
    // counts as free, since claim-over-done is the normal ID recycling case.
    always_comb begin
        w_claimed  = '0;
        w_multi    = '0;
        w_release  = '0;
        w_conflict = 1'b0;
        for (int v = 0; v < NrVInsn; v++) begin
            w_claimer[v] = '0;
            for (int f = 0; f < NrFUs; f++) begin
                if (claim_valid_i[f] && (claim_id_i[f] == IdW'(v))) begin
                    if (w_claimed[v]) begin
                        w_multi[v] = 1'b1;
                    end else begin
                        w_claimed[v] = 1'b1;
                        w_claimer[v] = FuW'(f);
                    end
                end
                if (vinsn_done_i[f][v] && (r_owner[v] == FuW'(f))) begin
                    w_release[v] = 1'b1;
                end
            end
            if (w_multi[v] || (w_claimed[v] && r_owned[v] && !w_release[v])) begin
                w_conflict = 1'b1;
            end
        end
    end

    // Ownership table and sticky conflict flag; a claim beats a same-cycle done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owned    <= '0;
            r_conflict <= 1'b0;
            for (int v = 0; v < NrVInsn; v++) begin
                r_owner[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NrVInsn; v++) begin
                if (w_claimed[v]) begin
                    r_owned[v] <= 1'b1;
                    r_owner[v] <= w_claimer[v];
                end else if (w_release[v]) begin
                    r_owned[v] <= 1'b0;
                end
            end
            if (w_conflict) begin
                r_conflict <= 1'b1;
            end
        end
    end

    // Input routing: ready depends only on registered state and mask_id_i,
    // never on the FU-side ready, so a full queue stays not-ready even when
    // it is popped in the same cycle.
    always_comb begin
        w_tgt      = '0;
        w_id_owned = 1'b0;
        for (int v = 0; v < NrVInsn; v++) begin
            if (mask_id_i == IdW'(v)) begin
                w_tgt      = r_owner[v];
                w_id_owned = r_owned[v];
            end
        end
        w_tgt_cnt = '0;
        for (int f = 0; f < NrFUs; f++) begin
            if (w_tgt == FuW'(f)) begin
                w_tgt_cnt = r_cnt[f];
            end
        end
        w_ready = w_id_owned && (w_tgt_cnt < DepthC);
    end

    assign mask_ready_o     = w_ready;
    assign claim_conflict_o = r_conflict;

    // Per-FU push/pop/flush. Flushed entries are the leading run of head
    // entries whose tag retires this cycle; a same-cycle pop of such a head
    // is already part of that run and is not removed twice.
    always_comb begin
        for (int f = 0; f < NrFUs; f++) begin
            logic run;
            w_push[f] = mask_valid_i && w_ready && (w_tgt == FuW'(f))
                        && !vinsn_done_i[f][mask_id_i];
            w_pop[f]  = (r_cnt[f] != '0) && fu_mask_ready_i[f];

            w_flush_cnt[f] = '0;
            run            = 1'b1;
            for (int i = 0; i < MaskQueueDepth; i++) begin
                if (run && (CntW'(i) < r_cnt[f])
                        && vinsn_done_i[f][r_tag[f][wrap_add(r_rptr[f], CntW'(i))]]) begin
                    w_flush_cnt[f] = w_flush_cnt[f] + CntW'(1);
                end else begin
                    run = 1'b0;
                end
            end

            if (w_flush_cnt[f] != '0) begin
                w_remove[f] = w_flush_cnt[f];
            end else begin
                w_remove[f] = w_pop[f] ? CntW'(1) : '0;
            end

            w_cnt_nxt[f]  = r_cnt[f] - w_remove[f] + CntW'(w_push[f]);
            w_rptr_nxt[f] = wrap_add(r_rptr[f], w_remove[f]);
            w_wptr_nxt[f] = w_push[f] ? wrap_add(r_wptr[f], CntW'(1)) : r_wptr[f];
        end
    end

    // Queue storage, pointers and occupancy counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int f = 0; f < NrFUs; f++) begin
                r_rptr[f] <= '0;
                r_wptr[f] <= '0;
                r_cnt[f]  <= '0;
                for (int i = 0; i < MaskQueueDepth; i++) begin
                    r_data[f][i] <= '0;
                    r_tag[f][i]  <= '0;
                end
            end
        end else begin
            for (int f = 0; f < NrFUs; f++) begin
                if (w_push[f]) begin
                    r_data[f][r_wptr[f]] <= mask_i;
                    r_tag[f][r_wptr[f]]  <= mask_id_i;
                end
                r_rptr[f] <= w_rptr_nxt[f];
                r_wptr[f] <= w_wptr_nxt[f];
                r_cnt[f]  <= w_cnt_nxt[f];
            end
        end
    end

    // Head-of-queue outputs, forced to zero while a queue is empty.
    always_comb begin
        for (int f = 0; f < NrFUs; f++) begin
            fu_mask_valid_o[f] = (r_cnt[f] != '0);
            if (r_cnt[f] != '0) begin
                fu_mask_o[f]    = r_data[f][r_rptr[f]];
                fu_mask_id_o[f] = r_tag[f][r_rptr[f]];
            end else begin
                fu_mask_o[f]    = '0;
                fu_mask_id_o[f] = '0;
            end
        end
    end

endmodule

// File: tb/tb_lane_mask_dispatcher.sv
// Testbench for lane_mask_dispatcher: scoreboard of expected beats per FU,
// filled on input handshakes and drained on FU-side handshakes.
module tb_lane_mask_dispatcher;

    localparam int NF    = 2;
    localparam int NV    = 8;
    localparam int DEPTH = 4;
    localparam int SW    = 8;
    localparam int IW    = 3;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic [NF-1:0]          claim_valid_i;
    logic [NF-1:0][IW-1:0]  claim_id_i;
    logic [NF-1:0][NV-1:0]  vinsn_done_i;
    logic [SW-1:0]          mask_i;
    logic [IW-1:0]          mask_id_i;
    logic                   mask_valid_i;
    logic                   mask_ready_o;
    logic [NF-1:0][SW-1:0]  fu_mask_o;
    logic [NF-1:0][IW-1:0]  fu_mask_id_o;
    logic [NF-1:0]          fu_mask_valid_o;
    logic [NF-1:0]          fu_mask_ready_i;
    logic                   claim_conflict_o;

    int          n_total;
    int          n_bad;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int          m_owner[NV];

    lane_mask_dispatcher #(
        .NrFUs          (NF),
        .NrVInsn        (NV),
        .MaskQueueDepth (DEPTH),
        .StrbWidth      (SW)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .claim_valid_i    (claim_valid_i),
        .claim_id_i       (claim_id_i),
        .vinsn_done_i     (vinsn_done_i),
        .mask_i           (mask_i),
        .mask_id_i        (mask_id_i),
        .mask_valid_i     (mask_valid_i),
        .mask_ready_o     (mask_ready_o),
        .fu_mask_o        (fu_mask_o),
        .fu_mask_id_o     (fu_mask_id_o),
        .fu_mask_valid_o  (fu_mask_valid_o),
        .fu_mask_ready_i  (fu_mask_ready_i),
        .claim_conflict_o (claim_conflict_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [SW-1:0] d, input int id);
        mask_i       = d;
        mask_id_i    = IW'(id);
        mask_valid_i = 1'b1;
    endtask

    task automatic claim(input int f, input int id);
        claim_valid_i    = '0;
        claim_valid_i[f] = 1'b1;
        claim_id_i[f]    = IW'(id);
        next_cyc();
        claim_valid_i    = '0;
        m_owner[id]      = f;
    endtask

    task automatic send(input string tag, input logic [SW-1:0] d, input int id);
        drive(d, id);
        @(negedge clk_i);
        chk_eq(tag, 32'(mask_ready_o), 32'd1);
        next_cyc();
    endtask

    // Scoreboard: record accepted beats by modelled owner, check FU outputs in order.
    always @(negedge clk_i) begin
        logic [31:0] got;
        logic [31:0] want;
        if (rst_ni === 1'b1) begin
            if (mask_valid_i && mask_ready_o) begin
                if (m_owner[mask_id_i] == 0) exp_q0.push_back({21'd0, mask_id_i, mask_i});
                else                         exp_q1.push_back({21'd0, mask_id_i, mask_i});
            end
            if (fu_mask_valid_o[0] && fu_mask_ready_i[0]) begin
                got  = {21'd0, fu_mask_id_o[0], fu_mask_o[0]};
                want = 32'hFFFF_FFFF;
                if (exp_q0.size() > 0) want = exp_q0.pop_front();
                chk_eq("sb_fu0", got, want);
            end
            if (fu_mask_valid_o[1] && fu_mask_ready_i[1]) begin
                got  = {21'd0, fu_mask_id_o[1], fu_mask_o[1]};
                want = 32'hFFFF_FFFF;
                if (exp_q1.size() > 0) want = exp_q1.pop_front();
                chk_eq("sb_fu1", got, want);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        for (int v = 0; v < NV; v++) m_owner[v] = -1;
        rst_ni          = 1'b0;
        claim_valid_i   = '0;
        claim_id_i      = '0;
        vinsn_done_i    = '0;
        mask_i          = '0;
        mask_id_i       = '0;
        mask_valid_i    = 1'b0;
        fu_mask_ready_i = '0;

        // Reset values
        repeat (2) next_cyc();
        @(negedge clk_i);
        chk_eq("rst_ready",    32'(mask_ready_o),     32'd0);
        chk_eq("rst_valid",    32'(fu_mask_valid_o),  32'd0);
        chk_eq("rst_conflict", 32'(claim_conflict_o), 32'd0);
        chk_eq("rst_data",     32'(fu_mask_o),        32'd0);
        next_cyc();
        rst_ni = 1'b1;
        next_cyc();

        // Basic routing: FU0 claims 3, FU1 claims 5 in the same cycle
        fu_mask_ready_i  = 2'b11;
        claim_valid_i    = 2'b11;
        claim_id_i[0]    = 3'd3;
        claim_id_i[1]    = 3'd5;
        next_cyc();
        claim_valid_i = '0;
        m_owner[3]    = 0;
        m_owner[5]    = 1;
        send("rt_rdy_a", 8'hAA, 5);
        drive(8'h0F, 3);
        @(negedge clk_i);
        chk_eq("rt_rdy_b",  32'(mask_ready_o),    32'd1);
        chk_eq("rt_vld_c2", 32'(fu_mask_valid_o), 32'b10);
        chk_eq("rt_fu1_c2", 32'(fu_mask_o[1]),    32'hAA);
        next_cyc();
        mask_valid_i = 1'b0;
        @(negedge clk_i);
        chk_eq("rt_vld_c3", 32'(fu_mask_valid_o), 32'b01);
        chk_eq("rt_fu0_c3", 32'(fu_mask_o[0]),    32'h0F);
        next_cyc();

        // Backpressure: fill FU0 queue, then one more stalls until a pop frees space
        claim(0, 1);
        fu_mask_ready_i[0] = 1'b0;
        for (int i = 0; i < DEPTH; i++) send("bp_rdy_fill", SW'(8'h10 + i), 1);
        drive(8'h1F, 1);
        @(negedge clk_i);
        chk_eq("bp_full",      32'(mask_ready_o), 32'd0);
        chk_eq("bp_head",      32'(fu_mask_o[0]), 32'h10);
        next_cyc();
        fu_mask_ready_i[0] = 1'b1;
        @(negedge clk_i);
        chk_eq("bp_full_pop",  32'(mask_ready_o), 32'd0);
        next_cyc();
        @(negedge clk_i);
        chk_eq("bp_after_pop", 32'(mask_ready_o), 32'd1);
        next_cyc();
        mask_valid_i = 1'b0;
        repeat (DEPTH + 2) next_cyc();
        @(negedge clk_i);
        chk_eq("bp_drained",   32'(fu_mask_valid_o[0]), 32'd0);
        next_cyc();

        // Unowned ID stalls until claimed; claim cycle still stalls
        drive(8'h66, 6);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk_eq("uo_stall", 32'(mask_ready_o), 32'd0);
            next_cyc();
        end
        claim_valid_i[1] = 1'b1;
        claim_id_i[1]    = 3'd6;
        @(negedge clk_i);
        chk_eq("uo_claim_cyc", 32'(mask_ready_o), 32'd0);
        next_cyc();
        claim_valid_i = '0;
        m_owner[6]    = 1;
        @(negedge clk_i);
        chk_eq("uo_accept", 32'(mask_ready_o), 32'd1);
        next_cyc();
        mask_valid_i = 1'b0;
        repeat (2) next_cyc();

        // Flush: two id-2 beats ahead of one id-4 beat in FU1, then done for id 2
        fu_mask_ready_i = 2'b01;
        claim(1, 2);
        claim(1, 4);
        send("fl_rdy", 8'h21, 2);
        send("fl_rdy", 8'h22, 2);
        send("fl_rdy", 8'h41, 4);
        mask_valid_i       = 1'b0;
        vinsn_done_i[1][2] = 1'b1;
        while (exp_q1.size() > 0 && exp_q1[0][10:8] == 3'd2) void'(exp_q1.pop_front());
        m_owner[2] = -1;
        @(negedge clk_i);
        chk_eq("fl_pre_vld", 32'(fu_mask_valid_o[1]), 32'd1);
        next_cyc();
        vinsn_done_i = '0;
        @(negedge clk_i);
        chk_eq("fl_vld",  32'(fu_mask_valid_o[1]), 32'd1);
        chk_eq("fl_id",   32'(fu_mask_id_o[1]),    32'd4);
        chk_eq("fl_data", 32'(fu_mask_o[1]),       32'h41);
        drive(8'h2F, 2);
        @(negedge clk_i);
        chk_eq("fl_released", 32'(mask_ready_o), 32'd0);
        next_cyc();
        mask_valid_i    = 1'b0;
        fu_mask_ready_i = 2'b11;
        next_cyc();
        @(negedge clk_i);
        chk_eq("fl_cnt1", 32'(fu_mask_valid_o[1]), 32'd0);
        next_cyc();

        // Conflict: both FUs claim 0 in one cycle; lowest index owns it
        claim_valid_i = 2'b11;
        claim_id_i[0] = 3'd0;
        claim_id_i[1] = 3'd0;
        @(negedge clk_i);
        chk_eq("cf_before", 32'(claim_conflict_o), 32'd0);
        next_cyc();
        claim_valid_i = '0;
        m_owner[0]    = 0;
        @(negedge clk_i);
        chk_eq("cf_set", 32'(claim_conflict_o), 32'd1);
        send("cf_rdy", 8'h55, 0);
        mask_valid_i = 1'b0;
        @(negedge clk_i);
        chk_eq("cf_route_vld", 32'(fu_mask_valid_o), 32'b01);
        chk_eq("cf_route_dat", 32'(fu_mask_o[0]),    32'h55);
        repeat (3) next_cyc();
        @(negedge clk_i);
        chk_eq("cf_sticky", 32'(claim_conflict_o), 32'd1);
        next_cyc();

        // Reset mid-stream with both queues holding a beat
        fu_mask_ready_i = 2'b00;
        send("rs_rdy", 8'h33, 3);
        send("rs_rdy", 8'h35, 5);
        drive(8'h3A, 3);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_eq("rs_async_vld",  32'(fu_mask_valid_o),  32'd0);
        chk_eq("rs_async_rdy",  32'(mask_ready_o),     32'd0);
        chk_eq("rs_async_conf", 32'(claim_conflict_o), 32'd0);
        exp_q0.delete();
        exp_q1.delete();
        for (int v = 0; v < NV; v++) m_owner[v] = -1;
        next_cyc();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk_eq("rs_tbl_empty", 32'(mask_ready_o),    32'd0);
        chk_eq("rs_vld_after", 32'(fu_mask_valid_o), 32'd0);
        next_cyc();
        mask_valid_i = 1'b0;
        next_cyc();

        chk_eq("sb_left0", 32'(exp_q0.size()), 32'd0);
        chk_eq("sb_left1", 32'(exp_q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
